// File: rtl/wbgpio_pkg.sv
// wbgpio_pkg: shared constants for the Wishbone GPIO block.
//   - Word offsets (adr[4:2]) of the eight registers in the 32-byte window.
//   - Legal ranges for the NUM_PINS and LATENCY parameters.
//   - lane_mask(): expands the four Wishbone byte selects into a 32-bit mask.
package wbgpio_pkg;

    localparam int NUM_PINS_MIN = 1;
    localparam int NUM_PINS_MAX = 32;
    localparam int LATENCY_MIN  = 1;
    localparam int LATENCY_MAX  = 8;

    // Word index inside the window; byte offset is index * 4.
    localparam logic [2:0] REG_OUT     = 3'd0;  // 0x00 rw
    localparam logic [2:0] REG_IN      = 3'd1;  // 0x04 ro, synchronised pins
    localparam logic [2:0] REG_DIR     = 3'd2;  // 0x08 rw, output enables
    localparam logic [2:0] REG_RISE_EN = 3'd3;  // 0x0C rw
    localparam logic [2:0] REG_FALL_EN = 3'd4;  // 0x10 rw
    localparam logic [2:0] REG_STATUS  = 3'd5;  // 0x14 read, write-1-to-clear
    localparam logic [2:0] REG_OUT_SET = 3'd6;  // 0x18 wo, reads 0
    localparam logic [2:0] REG_OUT_CLR = 3'd7;  // 0x1C wo, reads 0

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchroniser for asynchronous pin inputs, followed by
// a history flop used for edge detection.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_pins         raw asynchronous pin inputs
//   o_synced       synchronised pin value (last synchroniser stage)
//   o_rise/o_fall  one-cycle pulses on a synchronised 0->1 / 1->0 transition
module gpio_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_synced,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= i_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_synced = sync_q[SYNC_STAGES-1];
    assign o_rise   = o_synced & ~hist_q;
    assign o_fall   = ~o_synced & hist_q;

endmodule

// File: rtl/wbgpio.sv
// wbgpio: Wishbone (pipelined, never stalls) GPIO peripheral.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_wb_*/o_wb_*     Wishbone peripheral port: cyc, stb, we, sel, adr, dat
//                     in; dat, ack, stall out
//   o_gpio_out        OUT register
//   o_gpio_oe         DIR register (per-pin output enable)
//   i_gpio_in         asynchronous pin inputs
//   o_irq             registered OR of all STATUS bits
//
// Handshake: a request is accepted in any cycle with cyc & stb & an address
// inside the window; stall is tied low. Each accepted request gets exactly one
// ack LATENCY cycles after its acceptance cycle, in order, carrying read data
// captured at acceptance. Dropping cyc cancels every pending ack; writes that
// were already accepted stay committed.
module wbgpio
    import wbgpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          NUM_PINS    = 32,
    parameter int          LATENCY     = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [3:0]          i_wb_sel,
    input  logic [31:0]         i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    output logic [31:0]         o_wb_dat,
    output logic                o_wb_ack,
    output logic                o_wb_stall,
    output logic [NUM_PINS-1:0] o_gpio_out,
    output logic [NUM_PINS-1:0] o_gpio_oe,
    input  logic [NUM_PINS-1:0] i_gpio_in,
    output logic                o_irq
);

    typedef logic [NUM_PINS-1:0] pins_t;

    pins_t out_q, out_d;
    pins_t dir_q, dir_d;
    pins_t rise_en_q, rise_en_d;
    pins_t fall_en_q, fall_en_d;
    pins_t status_q, status_d;
    logic  irq_q;

    pins_t synced, rise, fall;
    pins_t wmask, wbits, w1c, edge_ev;
    logic  accept, wr;
    logic  [2:0]  reg_sel;
    logic  [31:0] rd_data;
    logic  unused_adr;

    logic [LATENCY-1:0] vld_q;
    logic [31:0]        dat_q [LATENCY];

    gpio_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NUM_PINS)
    ) u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pins   (i_gpio_in),
        .o_synced (synced),
        .o_rise   (rise),
        .o_fall   (fall)
    );

    // Byte address bits are not decoded: the window is word-addressed.
    assign unused_adr = ^i_wb_adr[1:0];

    assign accept  = i_wb_cyc & i_wb_stb & (i_wb_adr[31:5] == BASE_ADDR[31:5]);
    assign wr      = accept & i_wb_we;
    assign reg_sel = i_wb_adr[4:2];
    // Truncating to NUM_PINS makes bits above the pin count ignore writes.
    assign wmask   = pins_t'(lane_mask(i_wb_sel));
    assign wbits   = wmask & pins_t'(i_wb_dat);
    assign edge_ev = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        rd_data   = '0;

        if (wr) begin
            case (reg_sel)
                REG_OUT:     out_d     = (out_q & ~wmask) | wbits;
                REG_DIR:     dir_d     = (dir_q & ~wmask) | wbits;
                REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wbits;
                REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wbits;
                REG_STATUS:  w1c       = wbits;
                REG_OUT_SET: out_d     = out_q | wbits;
                REG_OUT_CLR: out_d     = out_q & ~wbits;
                default:     ;
            endcase
        end

        // Read data reflects register state before this cycle's write lands.
        if (accept && !i_wb_we) begin
            case (reg_sel)
                REG_OUT:     rd_data = 32'(out_q);
                REG_IN:      rd_data = 32'(synced);
                REG_DIR:     rd_data = 32'(dir_q);
                REG_RISE_EN: rd_data = 32'(rise_en_q);
                REG_FALL_EN: rd_data = 32'(fall_en_q);
                REG_STATUS:  rd_data = 32'(status_q);
                default:     rd_data = '0;
            endcase
        end

        // Clear first, then set: a new edge beats a simultaneous W1C.
        status_d = (status_q & ~w1c) | edge_ev;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= |status_q;
        end
    end

    // Ack/data delay line. Stage 0 is loaded at the end of the acceptance
    // cycle, so the last stage presents the ack LATENCY cycles after it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            dat_q[0] <= rd_data;
            for (int i = 1; i < LATENCY; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
            if (!i_wb_cyc) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
    end

    // Gating with cyc suppresses an ack that is due in the cycle cyc drops.
    assign o_wb_ack   = vld_q[LATENCY-1] & i_wb_cyc;
    assign o_wb_dat   = dat_q[LATENCY-1];
    assign o_wb_stall = 1'b0;
    assign o_gpio_out = out_q;
    assign o_gpio_oe  = dir_q;
    assign o_irq      = irq_q;

endmodule
